shift_unit_ctrl: RTL and testbench

- Multi-cycle controller that shares the single combinational logical-right shifter (SRL-only) between two requesters: the ALU issue port (req 0) and the load-align port (req 1).
- Round-robin arbitration between the two requesters.
- Builds SLL by bit-reversing the operand before and after the shift, and SRA by OR-ing a sign-fill mask.
- Returns one registered result per granted request over a valid/ready response handshake.

---
 rtl/shift_pkg.sv | 42 ++++
 rtl/rr_arb2.sv | 16 +
 rtl/shift_unit_ctrl.sv | 136 +++++++++++++
 tb/tb_shift_unit_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift-unit controller: funct codes, FSM state
// encoding, default widths and the bit-reverse helper used to build SLL from SRL.
package shift_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_SRA = 6'b000011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIX   = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Internal operation class derived from the funct code at grant time.
  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2,
    OP_ERR = 2'd3
  } op_e;

  function automatic logic [DEF_WIDTH-1:0] bit_reverse(input logic [DEF_WIDTH-1:0] d);
    logic [DEF_WIDTH-1:0] r;
    for (int i = 0; i < DEF_WIDTH; i++) r[i] = d[DEF_WIDTH-1-i];
    return r;
  endfunction

  function automatic op_e decode_funct(input logic [5:0] f);
    case (f)
      FUNCT_SLL: return OP_SLL;
      FUNCT_SRL: return OP_SRL;
      FUNCT_SRA: return OP_SRA;
      default:   return OP_ERR;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on contention
// the requester that was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant selection from the request vector and the last winner.
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/shift_unit_ctrl.sv
// Shares one SRL-only shifter between the ALU issue port (0) and the
// load-align port (1). SLL is built by reversing the operand before and the
// result after the shift; SRA ORs in a sign-fill mask after the shift.
module shift_unit_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [5:0]         req_funct0,
  input  logic [5:0]         req_funct1,
  input  logic [WIDTH-1:0]   req_data0,
  input  logic [WIDTH-1:0]   req_data1,
  input  logic [SHAMT_W-1:0] req_shamt0,
  input  logic [SHAMT_W-1:0] req_shamt1,
  output logic [WIDTH-1:0]   sh_dataA,
  output logic [WIDTH-1:0]   sh_dataB,
  output logic [5:0]         sh_signal,
  input  logic [WIDTH-1:0]   sh_dataOut,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_data,
  output logic               resp_id,
  output logic               resp_err,
  output logic               busy
);

  state_e               state;
  op_e                  op_q;
  logic [SHAMT_W-1:0]   shamt_q;
  logic [WIDTH-1:0]     cap_q;
  logic                 rr_last;

  logic [1:0]           grant;
  logic                 sel_id;
  logic [5:0]           sel_funct;
  logic [WIDTH-1:0]     sel_data;
  logic [SHAMT_W-1:0]   sel_shamt;
  op_e                  sel_op;
  logic [WIDTH-1:0]     fix_data;

  rr_arb2 u_arb (
    .req   (req_valid),
    .last  (rr_last),
    .grant (grant)
  );

  // Accept strobe is only offered while idle; reset masks it so every output
  // is quiet for as long as reset is held.
  assign req_ready = (state == ST_IDLE && !reset) ? grant : 2'b00;
  assign busy      = (state != ST_IDLE);

  // Select the granted requester's operands and classify its funct.
  always_comb begin
    sel_id    = grant[1];
    sel_funct = sel_id ? req_funct1 : req_funct0;
    sel_data  = sel_id ? req_data1  : req_data0;
    sel_shamt = sel_id ? req_shamt1 : req_shamt0;
    sel_op    = decode_funct(sel_funct);
  end

  // Post-shift fix-up: undo the SLL reversal or add the SRA sign fill.
  // sh_dataA still holds the unreversed operand for SRA, so its MSB is the sign.
  always_comb begin
    fix_data = cap_q;
    case (op_q)
      OP_SLL:  fix_data = bit_reverse(cap_q);
      OP_SRA:  if (sh_dataA[WIDTH-1]) fix_data = cap_q | ~({WIDTH{1'b1}} >> shamt_q);
      default: fix_data = cap_q;
    endcase
  end

  // Controller FSM with registered shifter drive and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_SRL;
      shamt_q    <= '0;
      cap_q      <= '0;
      rr_last    <= 1'b1;
      sh_dataA   <= '0;
      sh_dataB   <= '0;
      sh_signal  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            rr_last  <= sel_id;
            resp_id  <= sel_id;
            op_q     <= sel_op;
            shamt_q  <= sel_shamt;
            sh_dataA <= (sel_op == OP_SLL) ? bit_reverse(sel_data) : sel_data;
            sh_dataB <= {{(WIDTH-SHAMT_W){1'b0}}, sel_shamt};
            if (sel_op == OP_ERR) begin
              resp_err   <= 1'b1;
              resp_data  <= '0;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else begin
              resp_err  <= 1'b0;
              sh_signal <= FUNCT_SRL;
              state     <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          cap_q     <= sh_dataOut;
          sh_signal <= '0;
          state     <= ST_FIX;
        end
        ST_FIX: begin
          resp_data  <= fix_data;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Bench for shift_unit_ctrl with a behavioural SRL-only shifter. Expected
// responses are queued when a grant is seen and compared when the response
// handshake occurs.
module tb_shift_unit_ctrl;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_BAD = 6'b100000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [5:0]  req_funct0 = '0, req_funct1 = '0;
  logic [31:0] req_data0 = '0, req_data1 = '0;
  logic [4:0]  req_shamt0 = '0, req_shamt1 = '0;
  logic [31:0] sh_dataA, sh_dataB, sh_dataOut;
  logic [5:0]  sh_signal;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_id, resp_err, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          id;
    logic [31:0] data;
    bit          err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          id;
    logic [5:0]  funct;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  // Stand-in for the shared shifter: SRL when selected, garbage otherwise.
  assign sh_dataOut = (sh_signal == F_SRL) ? (sh_dataA >> sh_dataB) : 32'hDEAD_BEEF;

  shift_unit_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct0 (req_funct0),
    .req_funct1 (req_funct1),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_shamt0 (req_shamt0),
    .req_shamt1 (req_shamt1),
    .sh_dataA   (sh_dataA),
    .sh_dataB   (sh_dataB),
    .sh_signal  (sh_signal),
    .sh_dataOut (sh_dataOut),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got timeout expected event", name);
  endtask

  // Reference behaviour of the full shift unit, independent of the RTL method.
  function automatic exp_t model(input bit id, input logic [5:0] f, input logic [31:0] d,
                                 input logic [4:0] s);
    exp_t e;
    logic signed [31:0] sd;
    sd     = d;
    e.id   = id;
    e.err  = 1'b0;
    e.data = 32'h0;
    case (f)
      F_SLL:   e.data = d << s;
      F_SRL:   e.data = d >> s;
      F_SRA:   e.data = sd >>> s;
      default: e.err  = 1'b1;
    endcase
    return e;
  endfunction

  task automatic push(input bit id, input logic [31:0] d, input bit err);
    exp_t e;
    e.id = id; e.data = d; e.err = err;
    sb.push_back(e);
  endtask

  // Response monitor: compare against the scoreboard on each handshake.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got id %0d data %h expected no response", resp_id, resp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_id", 32'(resp_id), 32'(e.id));
        check("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the grant edge.
  task automatic issue(input bit id, input logic [5:0] f, input logic [31:0] d,
                       input logic [4:0] s, input logic [31:0] ed, input bit ee);
    bit ok = 1'b0;
    if (id) begin req_funct1 = f; req_data1 = d; req_shamt1 = s; end
    else    begin req_funct0 = f; req_data0 = d; req_shamt0 = s; end
    req_valid[id] = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      #1;
      if (req_ready[id]) begin
        push(id, ed, ee);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid[id] = 1'b0;
    if (!ok) fail_bound("grant_wait");
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((sb.size() != 0 || busy) && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 60) fail_bound("drain");
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, F_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0};
    vecs[1]  = '{1'b1, F_SRA, 32'hF000_0000, 5'd8,  32'hFFF0_0000, 1'b0};
    vecs[2]  = '{1'b1, F_SRA, 32'h7000_0000, 5'd8,  32'h0070_0000, 1'b0};
    vecs[3]  = '{1'b0, F_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    vecs[4]  = '{1'b0, F_SLL, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0};
    vecs[5]  = '{1'b1, F_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{1'b0, F_SRA, 32'h8000_0001, 5'd0,  32'h8000_0001, 1'b0};
    vecs[7]  = '{1'b1, F_SRL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
    vecs[8]  = '{1'b1, F_BAD, 32'h1234_5678, 5'd4,  32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, F_SLL, 32'h1234_5678, 5'd4,  32'h2345_6780, 1'b0};
    vecs[10] = '{1'b1, F_SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0};
    vecs[11] = '{1'b0, F_SRA, 32'h8765_4321, 5'd12, 32'hFFF8_7654, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_sh_signal", 32'(sh_signal), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    reset = 1'b0;

    // Latency: grant at t, SRL on the shifter at t+1, response at t+3.
    @(posedge clk); #1;
    req_funct0 = F_SRL; req_data0 = 32'h8000_0000; req_shamt0 = 5'd4;
    req_valid  = 2'b01;
    #1;
    check("lat_grant", 32'(req_ready), 32'h1);
    push(1'b0, 32'h0800_0000, 1'b0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("lat_sh_signal", 32'(sh_signal), 32'(F_SRL));
    check("lat_sh_dataA", sh_dataA, 32'h8000_0000);
    check("lat_sh_dataB", sh_dataB, 32'd4);
    check("lat_busy", 32'(busy), 32'h1);
    @(posedge clk); #1;
    check("lat_t2_valid", 32'(resp_valid), 32'h0);
    check("lat_t2_sh_signal", 32'(sh_signal), 32'h0);
    @(posedge clk); #1;
    check("lat_t3_valid", 32'(resp_valid), 32'h1);
    wait_drain();

    // Unsupported funct: response one cycle after the grant.
    req_funct1 = F_BAD; req_data1 = 32'h1234_5678; req_shamt1 = 5'd3;
    req_valid  = 2'b10;
    #1;
    check("err_grant", 32'(req_ready), 32'h2);
    push(1'b1, 32'h0, 1'b1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("err_t1_valid", 32'(resp_valid), 32'h1);
    check("err_t1_err", 32'(resp_err), 32'h1);
    check("err_t1_data", resp_data, 32'h0);
    wait_drain();

    // Table-driven single requests.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].id, vecs[i].funct, vecs[i].data, vecs[i].shamt,
            vecs[i].exp_data, vecs[i].exp_err);
      wait_drain();
    end

    // Continuous contention: grants alternate 0,1,0,1 every 4 cycles.
    apply_reset();
    begin
      int ng = 0;
      int cyc = 0;
      int last_t = 0;
      bit exp_g = 1'b0;
      req_funct0 = F_SRL; req_data0 = 32'hF0F0_0000; req_shamt0 = 5'd4;
      req_funct1 = F_SRA; req_data1 = 32'h8000_0000; req_shamt1 = 5'd2;
      req_valid  = 2'b11;
      resp_ready = 1'b1;
      while (ng < 6 && cyc < 100) begin
        #1;
        if (req_ready != 2'b00) begin
          check("rr_grant", 32'(req_ready), exp_g ? 32'h2 : 32'h1);
          if (ng > 0) check("rr_spacing", 32'(cyc - last_t), 32'd4);
          if (req_ready[1]) sb.push_back(model(1'b1, req_funct1, req_data1, req_shamt1));
          else              sb.push_back(model(1'b0, req_funct0, req_data0, req_shamt0));
          last_t = cyc;
          exp_g  = ~exp_g;
          ng++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      req_valid = 2'b00;
      if (ng < 6) fail_bound("rr_grants");
      wait_drain();
    end

    // Stall in RESP with a pending request waiting behind it.
    resp_ready = 1'b0;
    issue(1'b0, F_SRL, 32'hAAAA_5555, 5'd1, 32'h5555_2AAA, 1'b0);
    req_funct1 = F_SLL; req_data1 = 32'h0000_0001; req_shamt1 = 5'd4;
    req_valid  = 2'b10;
    begin
      int c = 0;
      while (!resp_valid && c < 10) begin
        @(posedge clk); #1;
        c++;
      end
      if (c >= 10) fail_bound("stall_resp_wait");
    end
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(resp_valid), 32'h1);
      check("stall_data", resp_data, 32'h5555_2AAA);
      check("stall_no_grant", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    #1;
    check("hs_no_grant", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    check("post_hs_grant", 32'(req_ready), 32'h2);
    push(1'b1, 32'h0000_0010, 1'b0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_drain();

    // Reset during SHIFT aborts the operation; requester 0 wins afterwards.
    issue(1'b0, F_SRL, 32'h0000_FF00, 5'd8, 32'h0000_00FF, 1'b0);
    check("abort_in_shift", 32'(sh_signal), 32'(F_SRL));
    req_funct0 = F_SRL; req_data0 = 32'h0000_0F00; req_shamt0 = 5'd4;
    req_funct1 = F_SRA; req_data1 = 32'hC000_0000; req_shamt1 = 5'd1;
    req_valid  = 2'b11;
    reset      = 1'b1;
    #1;
    sb.delete();
    check("abort_req_ready", 32'(req_ready), 32'h0);
    check("abort_sh_dataA", sh_dataA, 32'h0);
    check("abort_sh_dataB", sh_dataB, 32'h0);
    check("abort_sh_signal", 32'(sh_signal), 32'h0);
    check("abort_resp_valid", 32'(resp_valid), 32'h0);
    check("abort_resp_data", resp_data, 32'h0);
    check("abort_resp_id", 32'(resp_id), 32'h0);
    check("abort_resp_err", 32'(resp_err), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'h1);
    push(1'b0, 32'h0000_00F0, 1'b0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
